keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk_i cycles per column step; legal range is 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive identical full scans needed to accept a press or release; legal range 2..15.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port row_i  input  4  keypad rows, active-low (pulled up), asynchronous to clk_i.
REQ-006 SHALL have port clr_i  input  1  synchronous clear of data_o, active-high.
REQ-007 SHALL have port col_o  output  4  column drive, active-low one-hot.
REQ-008 SHALL have port key_valid_o  output  1  one-cycle pulse per accepted key press.
REQ-009 SHALL have port key_code_o  output  4  code of the last accepted key.
REQ-010 SHALL have port data_o  output  16  last four accepted codes, newest in [3:0]; intended to feed the 4-digit hex display data input.

Function
REQ-011 SHALL pass row_i through a 2-flop synchronizer before any use.
REQ-012 SHALL run a prescaler 0..SCAN_DIV-1; "tick" is the cycle the prescaler equals SCAN_DIV-1, after which it wraps to 0.
REQ-013 SHALL hold a 2-bit col_idx, drive col_o = ~(4'b0001 << col_idx), and increment col_idx on each tick, wrapping from 3 to 0.
REQ-014 SHALL, on each tick, sample the synchronized rows for the current col_idx before advancing col_idx.
REQ-015 SHALL encode a hit at row r, column c as key code {r[1:0], c[1:0]}.
REQ-016 SHALL end a full scan at the tick where col_idx==3, classifying the scan as NONE (no row low), SINGLE(code) (exactly one row low in exactly one column), or MULTI (anything else).
REQ-017 SHALL implement FSM states IDLE, DEBOUNCE, PRESSED and RELEASE, plus a scan counter cnt; the FSM and cnt are evaluated only at scan end.
REQ-018 IDLE: on SINGLE(K), SHALL set cand=K, cnt=1 and go to DEBOUNCE; on NONE or MULTI it SHALL stay in IDLE.
REQ-019 DEBOUNCE: on SINGLE(cand), SHALL increment cnt; when cnt reaches DEBOUNCE_SCANS it SHALL accept and go to PRESSED; on any other result it SHALL go to IDLE with cnt=0.
REQ-020 On accept, SHALL pulse key_valid_o high for exactly one cycle (the cycle after the scan-end tick), set key_code_o=cand, and set data_o={data_o[11:0],cand} in the same cycle.
REQ-021 PRESSED: on NONE, SHALL go to RELEASE with cnt=1; on SINGLE or MULTI it SHALL stay in PRESSED, with no auto-repeat even if the key changes.
REQ-022 RELEASE: on NONE, SHALL increment cnt and go to IDLE when cnt reaches DEBOUNCE_SCANS; on SINGLE or MULTI it SHALL return to PRESSED.
REQ-023 clr_i SHALL zero data_o on the next edge; if clr_i coincides with an accept, SHALL give the clear priority for data_o while key_valid_o and key_code_o still update.
REQ-024 key_code_o SHALL hold its value between accepts; key_valid_o SHALL never be high for two consecutive cycles.
REQ-025 Scan timing SHALL be free-running and independent of FSM state.

Reset
REQ-026 On rst_n_i low, SHALL immediately set col_o=4'b1110, key_valid_o=0, key_code_o=4'h0, data_o=16'h0000, FSM=IDLE, cnt=0, prescaler=0, and synchronizer flops=4'hF.
REQ-027 SHALL discard any in-progress debounce on reset, so that no accept follows reset release without a complete new DEBOUNCE_SCANS sequence.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3)
REQ-028 Bench SHALL cover: reset release -> col_o steps 1110, 1101, 1011, 0111, each held 4 cycles, then wraps to 1110; key_valid_o stays 0.
REQ-029 Bench SHALL cover: row1 pulled low whenever col_o==1011, held 5 scans -> exactly one key_valid_o pulse, key_code_o=4'h6, data_o=16'h0006.
REQ-030 Bench SHALL cover: press/release sequence for codes 1, 2, 3, A (each held 3+ scans, released 3+ scans) -> four pulses, data_o=16'h123A; then clr_i -> data_o=16'h0000 while key_code_o stays 4'hA.
REQ-031 Bench SHALL cover: bouncing key present 2 scans, absent 1, present 3 -> single pulse only after the final 3 consecutive scans.
REQ-032 Bench SHALL cover: two keys held together (codes 5 and 6) for 6 scans -> no pulse, data_o unchanged.
REQ-033 Bench SHALL cover: rst_n_i asserted for 2 cycles after 2 matching scans, key still held -> outputs at reset values immediately; the next pulse comes exactly 3 full scans after reset release.

Source files
------------

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan
//  Description : 4x4 matrix keypad scanner with full-scan debouncing. Drives
//                one active-low column at a time, classifies every complete
//                scan and accepts a key only after DEBOUNCE_SCANS identical
//                single-key scans. Accepted codes shift into a 16-bit history.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  row_i,
  input  logic        clr_i,
  output logic [3:0]  col_o,
  output logic        key_valid_o,
  output logic [3:0]  key_code_o,
  output logic [15:0] data_o
);

  localparam int             PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]  PRESC_ONE = PW'(1);
  localparam logic [3:0]     CNT_MAX   = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_e;

  // Synchronizer, scan timing and per-scan accumulation registers
  logic [3:0]    sync1_q, sync2_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    col_idx_q;
  logic [1:0]    acc_hits_q;   // saturating hit count: 0, 1, or 2 (=many)
  logic [3:0]    acc_code_q;

  // FSM and output registers
  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [3:0]    cand_q;
  logic          key_valid_q;
  logic [3:0]    key_code_q;
  logic [15:0]   data_q;

  // Combinational scan evaluation
  logic          tick;
  logic          scan_end;
  logic [3:0]    rows_low;
  logic [2:0]    col_hits;
  logic [1:0]    col_row;
  logic [1:0]    base_hits;
  logic [3:0]    base_code;
  logic [2:0]    hit_sum;
  logic [1:0]    hits_d;
  logic [3:0]    code_d;
  logic          res_none;
  logic          res_single;

  assign tick     = (presc_q == PRESC_MAX);
  assign scan_end = tick && (col_idx_q == 2'd3);

  // Two-flop synchronizer for the asynchronous, active-low row inputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= row_i;
      sync2_q <= sync1_q;
    end
  end

  // Free-running prescaler and column index; never influenced by the FSM
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc_q   <= '0;
      col_idx_q <= 2'd0;
    end else if (tick) begin
      presc_q   <= '0;
      col_idx_q <= col_idx_q + 2'd1;
    end else begin
      presc_q   <= presc_q + PRESC_ONE;
    end
  end

  assign col_o = ~(4'b0001 << col_idx_q);

  // Count low rows in the current column and remember which one was low
  always_comb begin
    rows_low = ~sync2_q;
    col_hits = 3'd0;
    col_row  = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (rows_low[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
  end

  // Fold this column's sample into the running scan result; column 0 restarts it
  always_comb begin
    base_hits = (col_idx_q == 2'd0) ? 2'd0 : acc_hits_q;
    base_code = (col_idx_q == 2'd0) ? 4'h0 : acc_code_q;
    hit_sum   = {1'b0, base_hits} + col_hits;
    hits_d    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    code_d    = (base_hits == 2'd0 && col_hits == 3'd1) ? {col_row, col_idx_q}
                                                        : base_code;
    res_none   = (hits_d == 2'd0);
    res_single = (hits_d == 2'd1);
  end

  // Capture the accumulated scan result at every column tick
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_hits_q <= 2'd0;
      acc_code_q <= 4'h0;
    end else if (tick) begin
      acc_hits_q <= hits_d;
      acc_code_q <= code_d;
    end
  end

  // Debounce FSM, evaluated once per full scan, with registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= 4'h0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      data_q      <= 16'h0000;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_end) begin
        case (state_q)
          S_IDLE: begin
            if (res_single) begin
              cand_q  <= code_d;
              cnt_q   <= 4'd1;
              state_q <= S_DEBOUNCE;
            end
          end
          S_DEBOUNCE: begin
            if (res_single && (code_d == cand_q)) begin
              if (cnt_q + 4'd1 == CNT_MAX) begin
                key_valid_q <= 1'b1;
                key_code_q  <= cand_q;
                data_q      <= {data_q[11:0], cand_q};
                cnt_q       <= 4'd0;
                state_q     <= S_PRESSED;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else begin
              cnt_q   <= 4'd0;
              state_q <= S_IDLE;
            end
          end
          S_PRESSED: begin
            // Any key activity keeps us here: no auto-repeat on key change
            if (res_none) begin
              cnt_q   <= 4'd1;
              state_q <= S_RELEASE;
            end
          end
          S_RELEASE: begin
            if (res_none) begin
              if (cnt_q + 4'd1 == CNT_MAX) begin
                cnt_q   <= 4'd0;
                state_q <= S_IDLE;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else begin
              cnt_q   <= 4'd0;
              state_q <= S_PRESSED;
            end
          end
          default: begin
            cnt_q   <= 4'd0;
            state_q <= S_IDLE;
          end
        endcase
      end
      // Clear wins over a coincident accept for the history register only
      if (clr_i) begin
        data_q <= 16'h0000;
      end
    end
  end

  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
  assign data_o      = data_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan
//  Description : Self-checking bench for keypad_scan (SCAN_DIV=4,
//                DEBOUNCE_SCANS=3) using a keypad model and a pulse scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

  localparam int DIV  = 4;
  localparam int DB   = 3;
  localparam int SCAN = 4 * DIV;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic        clr;
  logic [3:0]  col_o;
  logic        key_valid_o;
  logic [3:0]  key_code_o;
  logic [15:0] data_o;

  logic [15:0] held;       // one bit per key code currently pressed
  logic [15:0] exp_data;   // model of the accepted-code history
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic        prev_valid;
  int          total;
  int          bad;
  int          pulse_cnt;

  keypad_scan #(
    .SCAN_DIV       (DIV),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .row_i       (row),
    .clr_i       (clr),
    .col_o       (col_o),
    .key_valid_o (key_valid_o),
    .key_code_o  (key_code_o),
    .data_o      (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a held key {r,c} pulls row r low while column c is driven
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col_o[c] && held[r*4+c]) row[r] = 1'b0;
      end
    end
  end

  // Pulse monitor: every key_valid_o pulse is checked against the scoreboard
  initial begin
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (key_valid_o) begin
          pulse_cnt++;
          total++;
          if (prev_valid) begin
            bad++;
            $display("FAIL valid_double: key_valid_o=1 on two consecutive cycles, required single-cycle pulse");
          end
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: pulse with code %h, required no pulse", key_code_o);
          end else begin
            mon_e = sb_q.pop_front();
            total++;
            if (key_code_o !== mon_e.code) begin
              bad++;
              $display("FAIL pulse_code: key_code_o=%h required %h", key_code_o, mon_e.code);
            end
            total++;
            if (data_o !== mon_e.data) begin
              bad++;
              $display("FAIL pulse_data: data_o=%h required %h", data_o, mon_e.data);
            end
          end
        end
        prev_valid = key_valid_o;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input logic [3:0] code);
    exp_t e;
    exp_data  = {exp_data[11:0], code};
    e.code    = code;
    e.data    = exp_data;
    sb_q.push_back(e);
  endtask

  // Hold one key for hold_s scans, then release it for rel_s scans
  task automatic press(input logic [3:0] code, input int hold_s, input int rel_s);
    held = 16'h0001 << code;
    if (hold_s >= DB) push_expect(code);
    wait_cycles(hold_s * SCAN);
    held = 16'h0000;
    wait_cycles(rel_s * SCAN);
  endtask

  // Return #1 after the edge that starts a new scan (column 0 driven)
  task automatic sync_scan();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = col_o;
    for (int i = 0; i < 3 * SCAN && !found; i++) begin
      @(posedge clk);
      #1;
      if (prev == 4'b0111 && col_o == 4'b1110) found = 1'b1;
      prev = col_o;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL scan_align: no column wrap seen, col_o=%b required 1110 after 0111", col_o);
    end
  endtask

  task automatic check_drained(input string name, input int pulses_before, input int pulses_req);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL %s_pending: %0d expected pulses missing, required 0", name, sb_q.size());
      sb_q.delete();
    end
    total++;
    if (pulse_cnt - pulses_before != pulses_req) begin
      bad++;
      $display("FAIL %s_pulses: got %0d pulses, required %0d", name, pulse_cnt - pulses_before, pulses_req);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    rst_n = 1'b0;
    wait_cycles(3);
    total += 4;
    if (col_o !== 4'b1110) begin bad++; $display("FAIL rst_col: col_o=%b required 1110", col_o); end
    if (key_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: key_valid_o=%b required 0", key_valid_o); end
    if (key_code_o !== 4'h0) begin bad++; $display("FAIL rst_code: key_code_o=%h required 0", key_code_o); end
    if (data_o !== 16'h0000) begin bad++; $display("FAIL rst_data: data_o=%h required 0000", data_o); end
    rst_n = 1'b1;
    for (int i = 0; i < 5 * DIV + 1; i++) begin
      if (i > 0) wait_cycles(1);
      exp_col = 4'b0001 << ((i / DIV) % 4);
      exp_col = ~exp_col;
      total += 2;
      if (col_o !== exp_col) begin
        bad++;
        $display("FAIL col_step[%0d]: col_o=%b required %b", i, col_o, exp_col);
      end
      if (key_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL idle_valid[%0d]: key_valid_o=%b required 0", i, key_valid_o);
      end
    end
  endtask

  task automatic test_single_key();
    int p0;
    p0 = pulse_cnt;
    sync_scan();
    press(4'h6, 5, 4);
    check_drained("single", p0, 1);
    total += 2;
    if (key_code_o !== 4'h6) begin bad++; $display("FAIL single_code: key_code_o=%h required 6", key_code_o); end
    if (data_o !== 16'h0006) begin bad++; $display("FAIL single_data: data_o=%h required 0006", data_o); end
  endtask

  task automatic test_sequence_clear();
    int p0;
    p0 = pulse_cnt;
    sync_scan();
    press(4'h1, 3, 3);
    press(4'h2, 4, 3);
    press(4'h3, 3, 4);
    press(4'hA, 3, 3);
    check_drained("sequence", p0, 4);
    total++;
    if (data_o !== 16'h123A) begin bad++; $display("FAIL seq_data: data_o=%h required 123a", data_o); end
    clr = 1'b1;
    wait_cycles(1);
    clr = 1'b0;
    exp_data = 16'h0000;
    total += 2;
    if (data_o !== 16'h0000) begin bad++; $display("FAIL clr_data: data_o=%h required 0000", data_o); end
    if (key_code_o !== 4'hA) begin bad++; $display("FAIL clr_code: key_code_o=%h required a", key_code_o); end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulse_cnt;
    sync_scan();
    held = 16'h0001 << 9;
    wait_cycles(2 * SCAN);
    held = 16'h0000;
    wait_cycles(SCAN);
    held = 16'h0001 << 9;
    push_expect(4'h9);
    wait_cycles(3 * SCAN - 1);
    total += 2;
    if (key_valid_o !== 1'b0) begin bad++; $display("FAIL bounce_early: key_valid_o=%b required 0", key_valid_o); end
    if (pulse_cnt !== p0) begin bad++; $display("FAIL bounce_early_cnt: pulses=%0d required %0d", pulse_cnt, p0); end
    wait_cycles(1);
    total += 2;
    if (key_valid_o !== 1'b1) begin bad++; $display("FAIL bounce_pulse: key_valid_o=%b required 1", key_valid_o); end
    if (key_code_o !== 4'h9) begin bad++; $display("FAIL bounce_code: key_code_o=%h required 9", key_code_o); end
    held = 16'h0000;
    wait_cycles(4 * SCAN);
    check_drained("bounce", p0, 1);
  endtask

  task automatic test_multi_key();
    int p0;
    p0 = pulse_cnt;
    sync_scan();
    held = (16'h0001 << 5) | (16'h0001 << 6);
    wait_cycles(6 * SCAN);
    held = 16'h0000;
    wait_cycles(3 * SCAN);
    check_drained("multi", p0, 0);
    total++;
    if (data_o !== exp_data) begin bad++; $display("FAIL multi_data: data_o=%h required %h", data_o, exp_data); end
  endtask

  task automatic test_reset_midway();
    int p0;
    p0 = pulse_cnt;
    sync_scan();
    held = 16'h0001 << 12;
    wait_cycles(2 * SCAN);
    rst_n = 1'b0;
    #1;
    exp_data = 16'h0000;
    total += 4;
    if (col_o !== 4'b1110) begin bad++; $display("FAIL mid_rst_col: col_o=%b required 1110", col_o); end
    if (key_valid_o !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: key_valid_o=%b required 0", key_valid_o); end
    if (key_code_o !== 4'h0) begin bad++; $display("FAIL mid_rst_code: key_code_o=%h required 0", key_code_o); end
    if (data_o !== 16'h0000) begin bad++; $display("FAIL mid_rst_data: data_o=%h required 0000", data_o); end
    wait_cycles(2);
    rst_n = 1'b1;
    push_expect(4'hC);
    wait_cycles(3 * SCAN - 1);
    total++;
    if (key_valid_o !== 1'b0) begin bad++; $display("FAIL mid_early: key_valid_o=%b required 0", key_valid_o); end
    wait_cycles(1);
    total += 2;
    if (key_valid_o !== 1'b1) begin bad++; $display("FAIL mid_pulse: key_valid_o=%b required 1", key_valid_o); end
    if (key_code_o !== 4'hC) begin bad++; $display("FAIL mid_code: key_code_o=%h required c", key_code_o); end
    held = 16'h0000;
    wait_cycles(4 * SCAN);
    check_drained("midreset", p0, 1);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    pulse_cnt = 0;
    held      = 16'h0000;
    exp_data  = 16'h0000;
    clr       = 1'b0;
    rst_n     = 1'b0;
    test_reset();
    test_single_key();
    test_sequence_clear();
    test_bounce();
    test_multi_key();
    test_reset_midway();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
